unified_bus_arbiter: RTL and testbench

UNIFIED_BUS_ARBITER -- requirements
Module: unified_bus_arbiter

---
 rtl/riscv_bus_pkg.sv | 18 +
 rtl/bus_timeout_counter.sv | 37 +++
 rtl/unified_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_unified_bus_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_bus_pkg.sv
// Shared types for the unified bus arbiter: FSM states, requester ids and the
// fixed word access format used by instruction fetches.
package riscv_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } bus_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    localparam logic [2:0] FORMAT_WORD = 3'b010;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts BUSY cycles without an acknowledge and flags when the transaction
// has waited TIMEOUT_CYCLES cycles; the count is held at zero outside BUSY.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic busy_i,
    input  logic ack_i,
    output logic timeout_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] count_q;
    logic [7:0] count_d;

    assign timeout_o = busy_i && (count_q == LIMIT);

    always_comb begin
        count_d = count_q;
        if (!busy_i) begin
            count_d = '0;
        end else if (!ack_i && !timeout_o) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/unified_bus_arbiter.sv
// Shares one memory port between instruction fetch and data access, with a timeout abort.
// Define ROUND_ROBIN_EN to alternate simultaneous requests; otherwise data beats fetch.
module unified_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_format,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        m_req,
    output logic        m_we,
    output logic [2:0]  m_format,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    bus_state_e  state_q, state_d;
    logic        busy, timeout, done;
    logic        i_rvalid_q, d_rvalid_q, err_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        m_we_q;
    logic [2:0]  m_format_q;
    logic [31:0] m_addr_q, m_wdata_q;

`ifdef ROUND_ROBIN_EN
    req_id_e last_q;
`endif

    assign busy = (state_q != IDLE);
    assign done = busy && (m_ack || timeout);

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .busy_i   (busy),
        .ack_i    (m_ack),
        .timeout_o(timeout)
    );

    // Grants are only offered in IDLE, so at most one transaction is ever in flight.
    always_comb begin
        state_d = state_q;
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef ROUND_ROBIN_EN
                if (d_req && i_req) begin
                    d_gnt = (last_q == REQ_I);
                    i_gnt = (last_q == REQ_D);
                end else begin
                    d_gnt = d_req;
                    i_gnt = i_req;
                end
`else
                d_gnt = d_req;
                i_gnt = i_req && !d_req;
`endif
                if (d_gnt) begin
                    state_d = BUSY_D;
                end else if (i_gnt) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_req    = busy;
    assign m_we     = m_we_q;
    assign m_format = m_format_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign err      = err_q;

    // An abort returns zero data; an ack arriving with the timeout still counts as success.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            err_q      <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            m_we_q     <= 1'b0;
            m_format_q <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            i_rvalid_q <= (state_q == BUSY_I) && done;
            d_rvalid_q <= (state_q == BUSY_D) && done;
            err_q      <= busy && timeout && !m_ack;
            if (d_gnt) begin
                m_we_q     <= d_we;
                m_format_q <= d_format;
                m_addr_q   <= d_addr;
                m_wdata_q  <= d_wdata;
            end else if (i_gnt) begin
                m_we_q     <= 1'b0;
                m_format_q <= FORMAT_WORD;
                m_addr_q   <= i_addr;
                m_wdata_q  <= '0;
            end
            if ((state_q == BUSY_I) && done) begin
                i_rdata_q <= m_ack ? m_rdata : '0;
            end
            if ((state_q == BUSY_D) && done) begin
                d_rdata_q <= m_ack ? m_rdata : '0;
            end
        end
    end

`ifdef ROUND_ROBIN_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= REQ_I;
        end else if (d_gnt) begin
            last_q <= REQ_D;
        end else if (i_gnt) begin
            last_q <= REQ_I;
        end
    end
`endif

endmodule

// File: tb/tb_unified_bus_arbiter.sv
// Directed self-checking bench for unified_bus_arbiter (TIMEOUT_CYCLES = 3).
module tb_unified_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [2:0]  d_format = '0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        err;
    logic        m_req, m_we;
    logic [2:0]  m_format;
    logic [31:0] m_addr, m_wdata;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;

    int testsRun = 0;
    int testsFailed = 0;

    unified_bus_arbiter #(.TIMEOUT_CYCLES(3)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_format(d_format), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .err(err),
        .m_req(m_req), .m_we(m_we), .m_format(m_format), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got time limit reached, expected run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        testsRun++;
        if ({m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, err} !== 6'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b", {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, err}, 6'b0);
        end
        testsRun++;
        if ({i_rdata, d_rdata, m_addr, m_wdata, m_format, m_we} !== 132'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_regs: got %h expected 0", {i_rdata, d_rdata, m_addr, m_wdata, m_format, m_we});
        end
        reset = 1'b1;
        #1;
    endtask

    task automatic test_single_fetch();
        i_req = 1'b1; i_addr = 32'h100;
        #1;
        testsRun++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL fetch_grant: got %b expected %b", {i_gnt, d_gnt}, 2'b10);
        end
        step();
        i_req = 1'b0; i_addr = 32'hFFFF_FFFF;
        #1;
        testsRun++;
        if ({m_req, m_we, m_format, m_addr, m_wdata} !== {1'b1, 1'b0, 3'b010, 32'h100, 32'h0}) begin
            testsFailed++;
            $display("[TB] FAIL fetch_mport: got %h expected %h", {m_req, m_we, m_format, m_addr, m_wdata}, {1'b1, 1'b0, 3'b010, 32'h100, 32'h0});
        end
        step();
        m_ack = 1'b1; m_rdata = 32'h0000_0013;
        #1;
        step();
        m_ack = 1'b0; m_rdata = 32'h0;
        #1;
        testsRun++;
        if ({i_rvalid, err, m_req, i_rdata} !== {3'b100, 32'h13}) begin
            testsFailed++;
            $display("[TB] FAIL fetch_done: got %h expected %h", {i_rvalid, err, m_req, i_rdata}, {3'b100, 32'h13});
        end
        step();
        testsRun++;
        if ({i_rvalid, i_rdata} !== {1'b0, 32'h13}) begin
            testsFailed++;
            $display("[TB] FAIL fetch_pulse_hold: got %h expected %h", {i_rvalid, i_rdata}, {1'b0, 32'h13});
        end
    endtask

    task automatic test_priority();
        i_req = 1'b1; i_addr = 32'h204;
        d_req = 1'b1; d_we = 1'b0; d_format = 3'b010; d_addr = 32'h2000;
        #1;
        testsRun++;
        if ({d_gnt, i_gnt} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL prio_grant: got %b expected %b", {d_gnt, i_gnt}, 2'b10);
        end
        step();
        d_req = 1'b0;
        m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
        #1;
        testsRun++;
        if ({m_req, m_we, m_addr, i_gnt} !== {1'b1, 1'b0, 32'h2000, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL prio_busy: got %h expected %h", {m_req, m_we, m_addr, i_gnt}, {1'b1, 1'b0, 32'h2000, 1'b0});
        end
        step();
        m_ack = 1'b0;
        #1;
        testsRun++;
        if ({d_rvalid, i_gnt, d_gnt, d_rdata} !== {3'b110, 32'hDEAD_BEEF}) begin
            testsFailed++;
            $display("[TB] FAIL prio_b2b: got %h expected %h", {d_rvalid, i_gnt, d_gnt, d_rdata}, {3'b110, 32'hDEAD_BEEF});
        end
        step();
        i_req = 1'b0;
        m_ack = 1'b1; m_rdata = 32'h55;
        #1;
        testsRun++;
        if ({m_req, m_addr, m_format} !== {1'b1, 32'h204, 3'b010}) begin
            testsFailed++;
            $display("[TB] FAIL prio_fetch_mport: got %h expected %h", {m_req, m_addr, m_format}, {1'b1, 32'h204, 3'b010});
        end
        step();
        m_ack = 1'b0;
        #1;
        testsRun++;
        if ({i_rvalid, d_rvalid, i_rdata, d_rdata} !== {2'b10, 32'h55, 32'hDEAD_BEEF}) begin
            testsFailed++;
            $display("[TB] FAIL prio_fetch_done: got %h expected %h", {i_rvalid, d_rvalid, i_rdata, d_rdata}, {2'b10, 32'h55, 32'hDEAD_BEEF});
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] expD;
`ifdef ROUND_ROBIN_EN
        expD = 4'b0101;
`else
        expD = 4'b1111;
`endif
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_format = 3'b010; d_addr = 32'h3000;
        #1;
        for (int k = 0; k < 4; k++) begin
            testsRun++;
            if ({d_gnt, i_gnt} !== {expD[k], ~expD[k]}) begin
                testsFailed++;
                $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, {d_gnt, i_gnt}, {expD[k], ~expD[k]});
            end
            step();
            m_ack = 1'b1; m_rdata = 32'h1000 + k;
            #1;
            step();
            m_ack = 1'b0;
            if (k == 3) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            #1;
            testsRun++;
            if ({d_rvalid, i_rvalid, (expD[k] ? d_rdata : i_rdata)} !== {expD[k], ~expD[k], 32'h1000 + k}) begin
                testsFailed++;
                $display("[TB] FAIL rr_done_%0d: got %h expected %h", k, {d_rvalid, i_rvalid, (expD[k] ? d_rdata : i_rdata)}, {expD[k], ~expD[k], 32'h1000 + k});
            end
        end
        step();
    endtask

    task automatic test_timeout();
        d_req = 1'b1; d_we = 1'b0; d_format = 3'b010; d_addr = 32'h40;
        #1;
        step();
        d_req = 1'b0;
        #1;
        for (int c = 1; c <= 4; c++) begin
            testsRun++;
            if ({m_req, d_rvalid} !== 2'b10) begin
                testsFailed++;
                $display("[TB] FAIL to_wait_%0d: got %b expected %b", c, {m_req, d_rvalid}, 2'b10);
            end
            step();
        end
        testsRun++;
        if ({d_rvalid, err, m_req, d_rdata} !== {3'b110, 32'h0}) begin
            testsFailed++;
            $display("[TB] FAIL to_abort: got %h expected %h", {d_rvalid, err, m_req, d_rdata}, {3'b110, 32'h0});
        end
        step();
        testsRun++;
        if ({d_rvalid, err, m_req} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL to_after: got %b expected %b", {d_rvalid, err, m_req}, 3'b000);
        end
        // ack arriving in the same cycle the counter reaches the limit
        d_req = 1'b1;
        #1;
        step();
        d_req = 1'b0;
        #1;
        repeat (3) step();
        m_ack = 1'b1; m_rdata = 32'h77;
        #1;
        step();
        m_ack = 1'b0;
        #1;
        testsRun++;
        if ({d_rvalid, err, d_rdata} !== {2'b10, 32'h77}) begin
            testsFailed++;
            $display("[TB] FAIL to_ack_wins: got %h expected %h", {d_rvalid, err, d_rdata}, {2'b10, 32'h77});
        end
        // ack while idle must not produce any completion
        step();
        m_ack = 1'b1; m_rdata = 32'h99;
        #1;
        step();
        m_ack = 1'b0;
        #1;
        testsRun++;
        if ({d_rvalid, i_rvalid, err, m_req, d_rdata} !== {4'b0, 32'h77}) begin
            testsFailed++;
            $display("[TB] FAIL idle_ack: got %h expected %h", {d_rvalid, i_rvalid, err, m_req, d_rdata}, {4'b0, 32'h77});
        end
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_format = 3'b000; d_addr = 32'h3; d_wdata = 32'hAB;
        #1;
        testsRun++;
        if (d_gnt !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL st_grant: got %b expected %b", d_gnt, 1'b1);
        end
        step();
        d_req = 1'b0; d_we = 1'b0; d_format = 3'b111; d_addr = 32'hFFFF_0000; d_wdata = 32'h1234;
        #1;
        for (int c = 1; c <= 2; c++) begin
            if (c == 2) begin
                m_ack = 1'b1; m_rdata = 32'h5A5A;
                #1;
            end
            testsRun++;
            if ({m_req, m_we, m_format, m_addr, m_wdata} !== {2'b11, 3'b000, 32'h3, 32'hAB}) begin
                testsFailed++;
                $display("[TB] FAIL st_mport_%0d: got %h expected %h", c, {m_req, m_we, m_format, m_addr, m_wdata}, {2'b11, 3'b000, 32'h3, 32'hAB});
            end
            step();
        end
        m_ack = 1'b0;
        #1;
        testsRun++;
        if ({d_rvalid, err, m_req} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL st_done: got %b expected %b", {d_rvalid, err, m_req}, 3'b100);
        end
        step();
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_format = 3'b010; d_addr = 32'h88;
        #1;
        step();
        d_req = 1'b0;
        #1;
        testsRun++;
        if (m_req !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rst_busy: got %b expected %b", m_req, 1'b1);
        end
        #1;
        reset = 1'b0;
        #1;
        testsRun++;
        if ({m_req, d_rvalid, err} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL rst_async: got %b expected %b", {m_req, d_rvalid, err}, 3'b000);
        end
        m_ack = 1'b1;
        step();
        reset = 1'b1;
        #1;
        step();
        m_ack = 1'b0;
        #1;
        testsRun++;
        if ({m_req, d_rvalid, err, d_rdata} !== {3'b000, 32'h0}) begin
            testsFailed++;
            $display("[TB] FAIL rst_release: got %h expected %h", {m_req, d_rvalid, err, d_rdata}, {3'b000, 32'h0});
        end
        i_req = 1'b1; i_addr = 32'h400;
        #1;
        testsRun++;
        if (i_gnt !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rst_idle_grant: got %b expected %b", i_gnt, 1'b1);
        end
        step();
        i_req = 1'b0;
        m_ack = 1'b1; m_rdata = 32'h1;
        #1;
        step();
        m_ack = 1'b0;
        #1;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_priority();
        test_round_robin();
        test_timeout();
        test_store();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
